adapter_n_to_1_serial: RTL and testbench
========================================

ADAPTER_N_TO_1_SERIAL -- requirements
Module: adapter_n_to_1_serial

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one lane word.
REQ-002 SHALL have parameter N_INPUTS, default 4: number of lanes per packed input beat; legal range 2..16.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1: the in_data beat is offered.
REQ-007 SHALL have port in_ready, output, 1: the block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, N_INPUTS*DATA_WIDTH: packed lanes, with lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1: the sink accepts a word this cycle.
REQ-011 SHALL have port out_data, output, DATA_WIDTH: the current lane word.
REQ-012 SHALL have port out_lane, output, $clog2(N_INPUTS): index of the current lane.
REQ-013 SHALL have port out_last, output, 1: high when out_lane == N_INPUTS-1.
REQ-014 SHALL have port out_parity, output, 1: present only under ADAPTER_PARITY_EN.

Function
REQ-015 SHALL implement two states: IDLE (no data held) and SEND (holding a beat, emitting lanes).
REQ-016 SHALL transfer an input beat on in_valid && in_ready, and an output word on out_valid && out_ready.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==SEND && out_last && out_ready); this is combinational from out_ready.
REQ-018 SHALL, on an input transfer, register all N_INPUTS lanes, set the lane index to 0, and enter SEND on the next cycle (latency 1 clock from acceptance to the first out_valid).
REQ-019 SHALL drive out_valid = (state==SEND) and out_data = the registered lane at index out_lane.
REQ-020 SHALL emit lanes in order 0, 1, ..., N_INPUTS-1, advancing the index by one per output transfer only.
REQ-021 SHALL hold out_data, out_lane and out_last stable while out_valid && !out_ready (backpressure).
REQ-022 SHALL, on the output transfer of the last lane, return to IDLE if no input transfer occurs in the same cycle.
REQ-023 SHALL, on a simultaneous last-lane output transfer and input transfer, load the new beat, reset the index to 0 and stay in SEND, giving back-to-back streaming with no bubble.
REQ-024 SHALL ignore in_data and in_valid whenever in_ready is low, with no capture and no state change.
REQ-025 SHALL sustain a throughput of one word per clock while out_ready stays high.

Reset
REQ-026 SHALL, when reset is high at a clk edge, enter IDLE and clear the lane index and lane registers to 0, overriding any simultaneous transfer.
REQ-027 SHALL hold the following outputs while in reset or IDLE: out_valid=0, out_data=0, out_lane=0, out_last=0, out_parity=0, in_ready=1 (in_ready is 0 while reset is high).
REQ-028 SHALL, on a reset mid-SEND, discard the remaining lanes without emitting them.

Configuration
REQ-029 SHALL, with ADAPTER_PARITY_EN defined, add the out_parity port, driven to the XOR-reduction of out_data (even parity) and qualified by out_valid.
REQ-030 SHALL, without ADAPTER_PARITY_EN, omit the out_parity port and all parity logic, with identical behaviour on all other ports.

Verification
REQ-031 SHALL cover this scenario: default params, in_data=64'hCDEF_89AB_4567_0123, out_ready=1 -> out_data sequence 0123, 4567, 89AB, CDEF on 4 consecutive cycles, out_last only on CDEF, then IDLE.
REQ-032 SHALL cover this scenario: same beat, out_ready low for 3 cycles while out_lane=1 -> 4567 held stable, then the sequence resumes with 89AB.
REQ-033 SHALL cover this scenario: a second beat 64'h0123_00BB_0AAA_AAAA with in_valid held through the last lane -> AAAA immediately follows CDEF with no gap cycle.
REQ-034 SHALL cover this scenario: reset asserted while out_lane=2 -> the next cycle has out_valid=0 and in_ready=1, and 89AB/CDEF are never seen.
REQ-035 SHALL cover this scenario: with ADAPTER_PARITY_EN, lane word 16'h0001 gives out_parity=1 and 16'h0123 gives out_parity=0.
REQ-036 SHALL cover this scenario: with N_INPUTS=2 and DATA_WIDTH=8, in_data=16'hBEEF -> EF then BE, out_lane 0 then 1.

Source files
------------

// File: rtl/adapter_n_to_1_serial.sv
// N-lane to 1-lane serialiser: captures one packed beat and emits its lanes in order 0..N_INPUTS-1.
// Optional even-parity output is enabled by defining ADAPTER_PARITY_EN.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no beat held, ready for a new input beat
// SEND  | beat held, presenting lane r_lane
module adapter_n_to_1_serial #(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(N_INPUTS)-1:0]    out_lane,
`ifdef ADAPTER_PARITY_EN
    output logic                           out_parity,
`endif
    output logic                           out_last
);

    localparam int LANE_W = $clog2(N_INPUTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_lanes [N_INPUTS];
    logic [LANE_W-1:0]     r_lane;
    logic                  w_last;
    logic                  w_send;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    assign w_last     = (r_lane == LANE_W'(N_INPUTS - 1));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A last-lane transfer coinciding with a new beat keeps SEND for bubble-free streaming.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_in_xfer) w_state_nxt = ST_SEND;
            ST_SEND: if (w_out_xfer && w_last && !w_in_xfer) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is high so a reset mid-beat emits nothing more.
    always_comb begin
        w_send    = (r_state == ST_SEND) && !reset;
        out_valid = w_send;
        in_ready  = !reset && ((r_state == ST_IDLE) || ((r_state == ST_SEND) && w_last && out_ready));
        out_data  = w_send ? r_lanes[r_lane] : '0;
        out_lane  = w_send ? r_lane : '0;
        out_last  = w_send && w_last;
`ifdef ADAPTER_PARITY_EN
        out_parity = w_send && (^r_lanes[r_lane]);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                r_lanes[k] <= '0;
            end
            r_lane <= '0;
        end else if (w_in_xfer) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                r_lanes[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            r_lane <= '0;
        end else if (w_out_xfer) begin
            r_lane <= w_last ? '0 : r_lane + 1'b1;
        end
    end

endmodule

// File: tb/tb_adapter_n_to_1_serial.sv
// Bench for adapter_n_to_1_serial: queue-based reference model checked every cycle plus directed literal checks.
module tb_adapter_n_to_1_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // default-parameter instance
    logic        a_reset = 1'b1, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [63:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_last;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_lane;
`ifdef ADAPTER_PARITY_EN
    logic        a_out_parity;
`endif

    adapter_n_to_1_serial u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_lane  (a_out_lane),
`ifdef ADAPTER_PARITY_EN
        .out_parity(a_out_parity),
`endif
        .out_last  (a_out_last)
    );

    // two-lane, byte-wide instance
    logic        b_reset = 1'b1, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [15:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [7:0]  b_out_data;
    logic [0:0]  b_out_lane;
`ifdef ADAPTER_PARITY_EN
    logic        b_out_parity;
`endif

    adapter_n_to_1_serial #(.DATA_WIDTH(8), .N_INPUTS(2)) u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_lane  (b_out_lane),
`ifdef ADAPTER_PARITY_EN
        .out_parity(b_out_parity),
`endif
        .out_last  (b_out_last)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending lane words for instance A.
    typedef struct {
        logic [15:0] d;
        int          lane;
    } word_t;

    word_t       q[$];
    logic        m_valid = 1'b0, m_in_ready = 1'b0;
    logic [15:0] m_data;
    int          m_lane;

    always @(negedge clk) begin
        m_valid    = !a_reset && (q.size() > 0);
        m_in_ready = !a_reset && ((q.size() == 0) || ((q.size() == 1) && a_out_ready));
        m_data     = m_valid ? q[0].d : 16'h0;
        m_lane     = m_valid ? q[0].lane : 0;
        check("m.valid", 64'(a_out_valid), 64'(m_valid));
        check("m.in_ready", 64'(a_in_ready), 64'(m_in_ready));
        check("m.data", 64'(a_out_data), 64'(m_data));
        check("m.lane", 64'(a_out_lane), 64'(m_lane));
        check("m.last", 64'(a_out_last), 64'(m_valid && (m_lane == 3)));
`ifdef ADAPTER_PARITY_EN
        check("m.parity", 64'(a_out_parity), 64'(m_valid && (^m_data)));
`endif
    end

    always @(posedge clk) begin
        if (a_reset) begin
            q.delete();
        end else begin
            if (m_valid && a_out_ready) void'(q.pop_front());
            if (a_in_valid && m_in_ready) begin
                for (int k = 0; k < 4; k++) q.push_back('{a_in_data[k*16 +: 16], k});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal check of instance A at the negedge, then advance to just after the next posedge.
    task automatic chk_a(input string nm, input logic v, input logic rdy,
                         input logic [15:0] d, input logic [1:0] ln, input logic lst);
        @(negedge clk);
        check({nm, ".valid"}, 64'(a_out_valid), 64'(v));
        check({nm, ".in_ready"}, 64'(a_in_ready), 64'(rdy));
        check({nm, ".data"}, 64'(a_out_data), 64'(d));
        check({nm, ".lane"}, 64'(a_out_lane), 64'(ln));
        check({nm, ".last"}, 64'(a_out_last), 64'(lst));
        step();
    endtask

    localparam logic [63:0] BEAT_A = 64'hCDEF_89AB_4567_0123;
    localparam logic [63:0] BEAT_B = 64'h0123_00BB_0AAA_AAAA;

    logic [23:0] rdy_pat;

    initial begin
        step();
        chk_a("rst0", 0, 0, 16'h0, 0, 0);
        chk_a("rst1", 0, 0, 16'h0, 0, 0);
        a_reset = 1'b0;
        chk_a("idle", 0, 1, 16'h0, 0, 0);

        // straight four-lane burst
        a_in_valid = 1'b1; a_in_data = BEAT_A; a_out_ready = 1'b1;
        chk_a("s1_acc", 0, 1, 16'h0, 0, 0);
        a_in_valid = 1'b0;
        chk_a("s1_l0", 1, 0, 16'h0123, 0, 0);
        chk_a("s1_l1", 1, 0, 16'h4567, 1, 0);
        chk_a("s1_l2", 1, 0, 16'h89AB, 2, 0);
        chk_a("s1_l3", 1, 1, 16'hCDEF, 3, 1);
        chk_a("s1_idle", 0, 1, 16'h0, 0, 0);

        // backpressure on lane 1
        a_in_valid = 1'b1; a_in_data = BEAT_A;
        chk_a("s2_acc", 0, 1, 16'h0, 0, 0);
        a_in_valid = 1'b0;
        chk_a("s2_l0", 1, 0, 16'h0123, 0, 0);
        a_out_ready = 1'b0;
        chk_a("s2_hold0", 1, 0, 16'h4567, 1, 0);
        chk_a("s2_hold1", 1, 0, 16'h4567, 1, 0);
        chk_a("s2_hold2", 1, 0, 16'h4567, 1, 0);
        a_out_ready = 1'b1;
        chk_a("s2_l1", 1, 0, 16'h4567, 1, 0);
        chk_a("s2_l2", 1, 0, 16'h89AB, 2, 0);
        chk_a("s2_l3", 1, 1, 16'hCDEF, 3, 1);
        chk_a("s2_idle", 0, 1, 16'h0, 0, 0);

        // back-to-back beats, second beat offered early and ignored until the last lane
        a_in_valid = 1'b1; a_in_data = BEAT_A;
        chk_a("s3_acc", 0, 1, 16'h0, 0, 0);
        a_in_data = BEAT_B;
        chk_a("s3_a0", 1, 0, 16'h0123, 0, 0);
        chk_a("s3_a1", 1, 0, 16'h4567, 1, 0);
        chk_a("s3_a2", 1, 0, 16'h89AB, 2, 0);
        chk_a("s3_a3", 1, 1, 16'hCDEF, 3, 1);
        a_in_valid = 1'b0;
        chk_a("s3_b0", 1, 0, 16'hAAAA, 0, 0);
        chk_a("s3_b1", 1, 0, 16'h0AAA, 1, 0);
        chk_a("s3_b2", 1, 0, 16'h00BB, 2, 0);
        chk_a("s3_b3", 1, 1, 16'h0123, 3, 1);
        chk_a("s3_idle", 0, 1, 16'h0, 0, 0);

        // reset while lane 2 is presented
        a_in_valid = 1'b1; a_in_data = BEAT_A;
        chk_a("s4_acc", 0, 1, 16'h0, 0, 0);
        a_in_valid = 1'b0;
        chk_a("s4_l0", 1, 0, 16'h0123, 0, 0);
        chk_a("s4_l1", 1, 0, 16'h4567, 1, 0);
        a_reset = 1'b1;
        chk_a("s4_rst", 0, 0, 16'h0, 0, 0);
        a_reset = 1'b0;
        chk_a("s4_post0", 0, 1, 16'h0, 0, 0);
        chk_a("s4_post1", 0, 1, 16'h0, 0, 0);

`ifdef ADAPTER_PARITY_EN
        a_in_valid = 1'b1; a_in_data = 64'hCDEF_89AB_0123_0001;
        step();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("par_0001", 64'(a_out_parity), 64'(1));
        step();
        @(negedge clk);
        check("par_0123", 64'(a_out_parity), 64'(0));
        step(); step(); step();
`endif

        // mixed streaming under a fixed backpressure pattern, checked by the model
        rdy_pat = 24'b1011_0111_1100_1111_0101_1110;
        a_in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            a_out_ready = rdy_pat[c];
            a_in_data   = {16'(c * 4 + 3), 16'(c * 4 + 2), 16'hF000 | 16'(c), 16'(c * 257)};
            step();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        @(negedge clk);
        check("model_drained", 64'(q.size()), 64'(0));
        step();

        // two-lane byte-wide instance
        b_reset = 1'b0;
        step();
        b_in_valid = 1'b1; b_in_data = 16'hBEEF; b_out_ready = 1'b1;
        @(negedge clk);
        check("b_acc.in_ready", 64'(b_in_ready), 64'(1));
        step();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_l0.valid", 64'(b_out_valid), 64'(1));
        check("b_l0.data", 64'(b_out_data), 64'(8'hEF));
        check("b_l0.lane", 64'(b_out_lane), 64'(0));
        check("b_l0.last", 64'(b_out_last), 64'(0));
        step();
        @(negedge clk);
        check("b_l1.valid", 64'(b_out_valid), 64'(1));
        check("b_l1.data", 64'(b_out_data), 64'(8'hBE));
        check("b_l1.lane", 64'(b_out_lane), 64'(1));
        check("b_l1.last", 64'(b_out_last), 64'(1));
        step();
        @(negedge clk);
        check("b_idle.valid", 64'(b_out_valid), 64'(0));
        check("b_idle.in_ready", 64'(b_in_ready), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
